gcd_control: RTL
================

Name: gcd_control

Overview:
- Control FSM that drives the gcd_datapath through a subtractive Euclid GCD computation.
- Consumes the datapath status flags eqflg and ltflg, and produces the mux-select and register-load strobes.
- Presents a go/ready/done/err handshake to the surrounding system.
- Adds an iteration watchdog, so zero operands cannot hang the engine.

Parameters:
- MAX_ITER, 15, maximum subtraction steps before abort (15 covers the worst nonzero 4-bit pair, 15/1 = 14 steps).
- ITER_W, 4, iteration counter width; must satisfy MAX_ITER < 2**ITER_W.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  synchronous active-high reset; same net as the datapath clr.
- go  input  1  start request; sampled only in IDLE.
- eqflg  input  1  datapath flag: x == y.
- ltflg  input  1  datapath flag: x < y.
- xmsel  output  1  x mux select: 1 = xin, 0 = x-y.
- ymsel  output  1  y mux select: 1 = yin, 0 = y-x.
- xld  output  1  x register load strobe.
- yld  output  1  y register load strobe.
- gld  output  1  gcd output register load strobe.
- ready  output  1  high in IDLE; engine accepts go.
- done  output  1  one-cycle completion pulse (success or abort).
- err  output  1  abort status; valid with done, held until the next accepted go.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset clr is synchronous and active-high.
  - clr=1 forces IDLE and clears the iteration count. Next cycle: xmsel=ymsel=xld=yld=gld=done=err=0, ready=1.
  - clr overrides every state, including mid-computation; no strobe may assert in the cycle after clr.
- Outputs are Moore (decoded from registered state only). The flags are sampled in TEST only.
- States and transitions:
  - IDLE: ready=1.
    - go=1 -> LOAD; clear err and the iteration count.
    - go=0 -> stay.
  - LOAD: xmsel=ymsel=1, xld=yld=1 -> TEST.
    - xin/yin must be stable during the LOAD cycle, i.e. one cycle after go is accepted.
  - TEST: no strobes. Priority order:
    - eqflg=1 -> STORE.
    - else iteration count == MAX_ITER -> FAIL.
    - else ltflg=1 -> SUBY.
    - else -> SUBX.
  - SUBX: xmsel=0, xld=1; increment count -> TEST.
  - SUBY: ymsel=0, yld=1; increment count -> TEST.
  - STORE: gld=1 -> DONE.
  - DONE: done=1, err=0 -> IDLE.
  - FAIL: done=1, err=1, gld not asserted -> IDLE. The gcd output keeps its previous value.
- Strobe rules:
  - xld and yld are never both asserted in a subtraction state.
  - gld is asserted only in STORE.
- Latency, with go accepted at cycle 0 and n = number of subtractions:
  - TEST is first entered at cycle 2.
  - STORE at 3+2n, DONE (done pulse) at 4+2n.
  - gcd is valid from the DONE cycle onward.
- Abort timing: the count saturates the test at MAX_ITER, so FAIL is at cycle 3+2*MAX_ITER.
- Boundary cases:
  - go is ignored in every state other than IDLE; no queuing.
  - go held high continuously restarts a new computation on the cycle after DONE/FAIL returns to IDLE.
  - x=y=0: eqflg at the first TEST -> gcd=0, no err.
  - Exactly one operand zero: never converges -> FAIL, err=1.
  - Equal nonzero operands: n=0, done at cycle 4.
  - Simultaneous eqflg and ltflg cannot occur; eqflg wins if it does.

Test Plan:
- Reset, then go with xin=12, yin=8 -> subtract sequence SUBX, SUBY; gld at cycle 7; done at cycle 8; gcd=4; err=0.
- xin=15, yin=1 -> 14 SUBX steps; done at cycle 32; gcd=1; err=0; no abort.
- xin=5, yin=0 -> 15 SUBX steps; FAIL; done+err at cycle 33; gld never asserted; gcd retains the prior value 1.
- xin=9, yin=9 -> done at cycle 4, gcd=9. Then xin=0, yin=0 -> done at cycle 4, gcd=0, err=0.
- clr pulsed during the SUBY of the 12/8 run -> next cycle ready=1 and all strobes 0. A following go with 6/4 completes with gcd=2 at cycle 8.
- go pulsed while busy (cycle 3 of 12/8) -> ignored, result unchanged. go held high -> back-to-back runs, each starting one cycle after done.

Source files
------------

// File: rtl/gcd_control.sv
// gcd_control: control FSM for a subtractive Euclid GCD datapath.
// Drives the datapath mux selects and register load strobes from the
// eqflg/ltflg status flags, presents a go/ready/done/err handshake, and
// aborts via an iteration watchdog so zero operands cannot hang the engine.
//
// Ports:
//   clk    - system clock, rising edge
//   clr    - synchronous active-high reset (shared with datapath)
//   go     - start request, sampled only while idle
//   eqflg  - datapath flag x == y
//   ltflg  - datapath flag x < y
//   xmsel  - x mux select (1 = xin, 0 = x-y)
//   ymsel  - y mux select (1 = yin, 0 = y-x)
//   xld    - x register load strobe
//   yld    - y register load strobe
//   gld    - gcd output register load strobe
//   ready  - high while idle
//   done   - one-cycle completion pulse (success or abort)
//   err    - abort status, valid with done, held until next accepted go
module gcd_control #(
  parameter int unsigned MAX_ITER = 15,
  parameter int unsigned ITER_W   = 4   // MAX_ITER < 2**ITER_W
) (
  input  logic clk,
  input  logic clr,
  input  logic go,
  input  logic eqflg,
  input  logic ltflg,
  output logic xmsel,
  output logic ymsel,
  output logic xld,
  output logic yld,
  output logic gld,
  output logic ready,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_SUBX,
    S_SUBY,
    S_STORE,
    S_DONE,
    S_ABORT
  } state_t;

  state_t              state, state_n;
  logic [ITER_W-1:0]   iter, iter_n;
  logic                err_q, err_n;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      iter  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      iter  <= iter_n;
      err_q <= err_n;
    end
  end

  // err is a register rather than a state decode so it survives the
  // return to idle and stays visible until the next accepted go.
  assign err = err_q;

  always_comb begin
    state_n = state;
    iter_n  = iter;
    err_n   = err_q;
    xmsel   = 1'b0;
    ymsel   = 1'b0;
    xld     = 1'b0;
    yld     = 1'b0;
    gld     = 1'b0;
    ready   = 1'b0;
    done    = 1'b0;

    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (go) begin
          state_n = S_LOAD;
          err_n   = 1'b0;
          iter_n  = '0;
        end
      end
      S_LOAD: begin
        xmsel   = 1'b1;
        ymsel   = 1'b1;
        xld     = 1'b1;
        yld     = 1'b1;
        state_n = S_TEST;
      end
      S_TEST: begin
        // Equality is checked before the watchdog so a pair that converges
        // on the final permitted step still succeeds.
        if (eqflg) begin
          state_n = S_STORE;
        end else if (iter == ITER_W'(MAX_ITER)) begin
          state_n = S_ABORT;
          err_n   = 1'b1;
        end else if (ltflg) begin
          state_n = S_SUBY;
        end else begin
          state_n = S_SUBX;
        end
      end
      S_SUBX: begin
        xld     = 1'b1;
        iter_n  = iter + ITER_W'(1);
        state_n = S_TEST;
      end
      S_SUBY: begin
        yld     = 1'b1;
        iter_n  = iter + ITER_W'(1);
        state_n = S_TEST;
      end
      S_STORE: begin
        gld     = 1'b1;
        state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      S_ABORT: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
